// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if: request/grant bundle between the requesters and the mux arbiter
//   req        requester -> arbiter, one level per requester
//   mux_select arbiter -> mux select, all-ones when no owner
//   grant      arbiter -> requesters, one-hot owner or zero
//   busy       high while an owner holds the mux
//   preempt    one-cycle pulse when an owner is cut off by timeout
interface mux_rr_arbiter_if #(
    parameter int N_REQ = 7,
    parameter int SEL_W = 3
);
    logic [N_REQ-1:0] req;
    logic [SEL_W-1:0] mux_select;
    logic [N_REQ-1:0] grant;
    logic             busy;
    logic             preempt;
    modport master (output req, input mux_select, grant, busy, preempt);
    modport slave  (input req, output mux_select, grant, busy, preempt);
endinterface

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner selection for a shared 7:1 mux with a one-cycle dead gap
//   clk, rst  rising-edge clock, synchronous active-high reset
//   bus       mux_rr_arbiter_if.slave (req in; mux_select, grant, busy, preempt out)
//   MUX_ARB_TIMEOUT_EN defined: owners are preempted after HOLD_CYCLES grant cycles
module mux_rr_arbiter #(
    parameter int N_REQ = 7,
    parameter int SEL_W = 3
`ifdef MUX_ARB_TIMEOUT_EN
    , parameter int HOLD_CYCLES = 4
`endif
) (
    input logic              clk,
    input logic              rst,
    mux_rr_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;
    state_t           state_q, state_d;
    logic [SEL_W-1:0] last_q, last_d, sel_q, sel_d, win, idx;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             busy_q, busy_d, pre_q, pre_d, timeout;
    // Walk from the lowest priority (last owner) up to the highest so the last hit wins.
    always_comb begin
        win = last_q;
        idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = SEL_W'((int'(last_q) + k) % N_REQ);
            if (bus.req[idx]) win = idx;
        end
    end
    always_comb begin
        state_d = state_q;
        if (state_q == GRANT) state_d = (!bus.req[last_q] || timeout) ? GAP : GRANT;
        else state_d = |bus.req ? GRANT : IDLE;
    end
    // last_q doubles as the current owner index while in GRANT.
    always_comb begin
        last_d  = (state_q != GRANT && |bus.req) ? win : last_q;
        busy_d  = state_d == GRANT;
        grant_d = busy_d ? N_REQ'(1) << last_d : '0;
        sel_d   = busy_d ? last_d : '1;
        pre_d   = state_q == GRANT && bus.req[last_q] && timeout;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= SEL_W'(N_REQ - 1);
            sel_q   <= '1;
            grant_q <= '0;
            busy_q  <= 1'b0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            pre_q   <= pre_d;
        end
    end
`ifdef MUX_ARB_TIMEOUT_EN
    localparam int HW = $clog2(HOLD_CYCLES + 1) + 1;
    logic [HW-1:0] hold_q, hold_d;
    assign timeout = hold_q == HW'(HOLD_CYCLES);
    always_comb hold_d = state_d != GRANT ? '0 : state_q != GRANT ? HW'(1) : hold_q + HW'(hold_q != '1);
    always_ff @(posedge clk) begin
        if (rst) hold_q <= '0;
        else hold_q <= hold_d;
    end
`else
    assign timeout = 1'b0;
`endif
    assign bus.mux_select = sel_q;
    assign bus.grant      = grant_q;
    assign bus.busy       = busy_q;
    assign bus.preempt    = pre_q;
endmodule
